alu_exec_control: RTL and testbench

Sequenced ALU control for the multi-cycle core's execute stage. It decodes `alu_op`/`func` into the 4-bit ALU operation code used by the datapath ALU, and adds the RV32M multiply/divide group. Multiply and divide run on an internal iterative engine. Requests are accepted over a valid/ready handshake, and results are returned over a second valid/ready handshake.

---
 rtl/alu_exec_pkg.sv | 43 ++++
 rtl/alu_exec_control_muldiv.sv | 92 +++++++++
 rtl/alu_exec_control.sv | 171 +++++++++++++++++
 tb/tb_alu_exec_control.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared constants and types for alu_exec_control
//
// Contents: alu_op type codes, ALU operation codes, M-group funct3 codes,
// and the control FSM state type.
package alu_exec_pkg;

  // alu_op instruction type
  localparam logic [2:0] OP_R       = 3'b000;
  localparam logic [2:0] OP_I_ARITH = 3'b001;
  localparam logic [2:0] OP_S       = 3'b010;
  localparam logic [2:0] OP_SB      = 3'b011;
  localparam logic [2:0] OP_I_LOAD  = 3'b100;

  // datapath ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_CMPU = 4'b1010;

  // M-group funct3
  localparam logic [2:0] MF_MUL    = 3'b000;
  localparam logic [2:0] MF_MULH   = 3'b001;
  localparam logic [2:0] MF_MULHSU = 3'b010;
  localparam logic [2:0] MF_MULHU  = 3'b011;
  localparam logic [2:0] MF_DIV    = 3'b100;
  localparam logic [2:0] MF_DIVU   = 3'b101;
  localparam logic [2:0] MF_REM    = 3'b110;
  localparam logic [2:0] MF_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_exec_control_muldiv.sv
// rtl/alu_exec_control_muldiv.sv - iterative multiply/divide engine (muldiv_iter)
//
// Ports: start/op/a/b load a new operation (op = M funct3); done pulses
// during the last iteration cycle, when result already holds the signed,
// fixed-up answer. Magnitudes are iterated; sign is applied on that cycle.
module muldiv_iter
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;     // multiplicand or divisor magnitude
  logic [2:0]        op_q;
  logic              neg_res;
  logic              neg_rem;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_t, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_r;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn = op[2] ? ~op[0] : ~op[1];
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_t    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_t - {1'b0, opnd};
    div_ge   = ~div_diff[XLEN];
    div_r    = div_ge ? div_diff[XLEN-1:0] : div_t[XLEN-1:0];
    acc_next = op_q[2] ? {div_r, acc[XLEN-2:0], div_ge}
                       : {mul_sum, acc[XLEN-1:1]};
    prod     = neg_res ? -acc_next : acc_next;
    quo      = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem      = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      MF_MUL:                     result = prod[XLEN-1:0];
      MF_MULH, MF_MULHSU, MF_MULHU: result = prod[2*XLEN-1:XLEN];
      MF_DIV, MF_DIVU:            result = quo;
      default:                    result = rem;
    endcase
  end

  assign done = busy && (cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= MF_MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      op_q    <= op;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      acc     <= op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
      opnd    <= op[2] ? b_mag : a_mag;
    end else if (busy) begin
      acc <= acc_next;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_control.sv
// rtl/alu_exec_control.sv - execute-stage ALU decode with iterative RV32M unit
//
// Ports: in_valid/in_ready request handshake carrying alu_op, func, rs1, rs2;
// out_valid/out_ready result handshake carrying alu_operation, md_valid,
// md_result, illegal. Macro ALU_EXEC_MULDIV_EN enables the M group; without
// it M encodings are flagged illegal and md_valid/md_result stay 0.
module alu_exec_control
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [4:0]      func,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_operation,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result,
  output logic            illegal
);
  state_t          state;
  logic            accept;
  logic [3:0]      dec_code;
  logic            dec_illegal, dec_m, dec_special, md_done;
  logic [XLEN-1:0] spec_result, md_iter_result;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // dec_code stays ALU_ADD (0000) on every illegal or M path
  always_comb begin
    dec_code    = ALU_ADD;
    dec_illegal = 1'b0;
    dec_m       = 1'b0;
    if (func[4] && (alu_op == OP_R)) begin
`ifdef ALU_EXEC_MULDIV_EN
      dec_m = 1'b1;
`else
      dec_illegal = 1'b1;
`endif
    end else if (func[4]) begin
      dec_illegal = 1'b1;
    end else begin
      case (alu_op)
        OP_R: begin
          case (func[3:0])
            4'b0000: dec_code = ALU_ADD;
            4'b1000: dec_code = ALU_SUB;
            4'b0001: dec_code = ALU_SLL;
            4'b0010: dec_code = ALU_SLT;
            4'b0011: dec_code = ALU_SLTU;
            4'b0100: dec_code = ALU_XOR;
            4'b0101: dec_code = ALU_SRL;
            4'b1101: dec_code = ALU_SRA;
            4'b0110: dec_code = ALU_OR;
            4'b0111: dec_code = ALU_AND;
            default: dec_illegal = 1'b1;
          endcase
        end
        OP_I_ARITH: begin
          case (func[2:0])
            3'b000:  dec_code = ALU_ADD;
            3'b001:  dec_code = ALU_SLL;
            3'b010:  dec_code = ALU_SLT;
            3'b011:  dec_code = ALU_SLTU;
            3'b100:  dec_code = ALU_XOR;
            3'b101:  dec_code = func[3] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_code = ALU_OR;
            default: dec_code = ALU_AND;
          endcase
        end
        OP_I_LOAD: begin
          case (func[2:0])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_code = ALU_ADD;
            default: dec_illegal = 1'b1;
          endcase
        end
        OP_S: begin
          case (func[2:0])
            3'b000, 3'b001, 3'b010: dec_code = ALU_ADD;
            default: dec_illegal = 1'b1;
          endcase
        end
        OP_SB: begin
          case (func[2:0])
            3'b000, 3'b001, 3'b100, 3'b101: dec_code = ALU_SUB;
            3'b110, 3'b111:                 dec_code = ALU_CMPU;
            default: dec_illegal = 1'b1;
          endcase
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

`ifdef ALU_EXEC_MULDIV_EN
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic div_zero, div_ovf, md_start;

  // divide-by-zero and signed overflow bypass the engine entirely
  assign div_zero    = func[2] && (rs2 == '0);
  assign div_ovf     = func[2] && !func[0] && (rs1 == XMIN) && (rs2 == '1);
  assign dec_special = dec_m && (div_zero || div_ovf);
  assign spec_result = div_zero ? (func[1] ? rs1 : '1) : (func[1] ? '0 : XMIN);
  assign md_start    = accept && dec_m && !dec_special;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .op      (func[2:0]),
    .a       (rs1),
    .b       (rs2),
    .done    (md_done),
    .result  (md_iter_result)
  );
`else
  logic unused_ops;
  assign unused_ops     = ^{rs1, rs2};
  assign dec_special    = 1'b0;
  assign spec_result    = '0;
  assign md_done        = 1'b0;
  assign md_iter_result = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      alu_operation <= ALU_ADD;
      md_valid      <= 1'b0;
      md_result     <= '0;
      illegal       <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          if (md_done) begin
            state         <= S_DONE;
            alu_operation <= ALU_ADD;
            md_valid      <= 1'b1;
            md_result     <= md_iter_result;
            illegal       <= 1'b0;
          end
        end
        default: begin
          // accept in DONE retires the old result and loads the new one
          if (accept) begin
            if (dec_m && !dec_special) begin
              state <= S_CALC;
            end else begin
              state         <= S_DONE;
              alu_operation <= dec_code;
              md_valid      <= dec_m;
              md_result     <= dec_m ? spec_result : '0;
              illegal       <= dec_illegal;
            end
          end else if ((state != S_DONE) || out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_control.sv
// tb/tb_alu_exec_control.sv - scoreboard bench for alu_exec_control
module tb_alu_exec_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = 3'b0;
  logic [4:0]  func = 5'b0;
  logic [31:0] rs1 = 32'b0;
  logic [31:0] rs2 = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_operation;
  logic        md_valid;
  logic [31:0] md_result;
  logic        illegal;

  alu_exec_control #(.XLEN(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .func          (func),
    .rs1           (rs1),
    .rs2           (rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_operation (alu_operation),
    .md_valid      (md_valid),
    .md_result     (md_result),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic        mdv;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  bit   rdy_rand = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int r_code(input logic [3:0] f);
    case (f)
      4'b0000: return 0;
      4'b1000: return 1;
      4'b0111: return 2;
      4'b0110: return 3;
      4'b0100: return 4;
      4'b0001: return 5;
      4'b0010: return 6;
      4'b0011: return 7;
      4'b0101: return 8;
      4'b1101: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb2, p;
    logic [63:0] pu;
    logic        ovf;
    sa  = $signed(a);
    sb2 = $signed(b);
    pu  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f3)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ovf) return 32'h8000_0000;
        p = sa / sb2; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb2; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   code;
    e.code = 4'b0; e.mdv = 1'b0; e.res = 32'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    code = -1;
    if (op == 3'b000 && f[4]) begin
`ifdef ALU_EXEC_MULDIV_EN
      e.mdv = 1'b1;
      e.res = md_ref(f[2:0], a, b);
      if (!(f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff))))
        e.lat = 33;
`else
      e.ill = 1'b1;
`endif
      return e;
    end
    if (!f[4]) begin
      case (op)
        3'b000: code = r_code(f[3:0]);
        3'b001: code = (f[2:0] == 3'b101) ? (f[3] ? 9 : 8) : r_code({1'b0, f[2:0]});
        3'b100: code = (f[2:0] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? 0 : -1;
        3'b010: code = (f[2:0] <= 3'd2) ? 0 : -1;
        3'b011: code = (f[2:0] inside {3'd0, 3'd1, 3'd4, 3'd5}) ? 1 : ((f[2:0] >= 3'd6) ? 10 : -1);
        default: code = -1;
      endcase
    end
    if (code < 0) e.ill = 1'b1;
    else e.code = code[3:0];
    return e;
  endfunction

  // call at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    alu_op = op; func = f; rs1 = a; rs2 = b; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) break;
    end
    if (t > 200) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(op, f, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // monitor: compares every presented cycle, pops on handshake
  bit presented = 0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      presented = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb[0];
        if (!presented) begin
          presented = 1;
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
        chk("alu_operation", 64'(alu_operation), 64'(e.code));
        chk("md_valid", 64'(md_valid), 64'(e.mdv));
        chk("md_result", 64'(md_result), 64'(e.res));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("in_ready_in_done", 64'(in_ready), 64'(out_ready));
        if (out_ready) begin
          void'(sb.pop_front());
          presented = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [4:0] r_funcs [10];
    r_funcs = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011,
                5'b00100, 5'b00101, 5'b01101, 5'b00110, 5'b00111};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_operation", 64'(alu_operation), 64'd0);
    chk("rst_md_valid", 64'(md_valid), 64'd0);
    chk("rst_md_result", 64'(md_result), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // R-type sweep back to back, then I-arith/SB/S points
    for (int i = 0; i < 10; i++) issue(3'b000, r_funcs[i], $urandom, $urandom);
    issue(3'b001, 5'b00101, 32'h0, 32'h0);
    issue(3'b001, 5'b01101, 32'h0, 32'h0);
    issue(3'b011, 5'b00110, 32'h0, 32'h0);
    issue(3'b010, 5'b00011, 32'h0, 32'h0);
    issue(3'b100, 5'b00100, 32'h0, 32'h0);

    // M group directed
    issue(3'b000, 5'b10001, 32'h8000_0000, 32'h8000_0000);
    issue(3'b000, 5'b10000, 32'hffff_fffd, 32'd7);
    issue(3'b000, 5'b10100, 32'd7, 32'd0);
    issue(3'b000, 5'b10110, 32'd7, 32'd0);
    issue(3'b000, 5'b10100, 32'h8000_0000, 32'hffff_ffff);
    issue(3'b000, 5'b10110, 32'hffff_fff9, 32'd2);
    issue(3'b000, 5'b10010, 32'hffff_fff0, 32'hffff_ffff);
    issue(3'b000, 5'b10011, 32'hffff_ffff, 32'hffff_ffff);
    wait_drain();

    // back-pressure hold, then same-edge handoff
    out_ready = 1'b0;
    issue(3'b000, 5'b00100, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(3'b011, 5'b00111, 32'h0, 32'h0);
    wait_drain();

    // reset abort during CALC
    issue(3'b000, 5'b10100, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_alu_operation", 64'(alu_operation), 64'd0);
    chk("abort_md_valid", 64'(md_valid), 64'd0);
    chk("abort_md_result", 64'(md_result), 64'd0);
    chk("abort_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'b000, 5'b10101, 32'd100, 32'd7);
    wait_drain();

    // randomized traffic with random back-pressure
    rdy_rand = 1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] op;
      logic [4:0] f;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) op = 3'b000;
      f = 5'($urandom);
      if (op == 3'b000 && f[4]) f[3] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(op, f, pick_opnd(), pick_opnd());
    end
    wait_drain();
    rdy_rand = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
